// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table, scan state type and output polarity helper
package seg7_pkg;
  typedef enum logic {ST_DEAD, ST_ON} scan_state_e;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  function automatic logic [7:0] seg_pol(input logic [7:0] v, input logic act_low);
    return act_low ? ~v : v;
  endfunction
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: digit code to active-high {a..g,dp}, with BCD/hex and blanking
import seg7_pkg::*;
module seg7_encode (
  input  logic [3:0] i_code,
  input  logic       i_hex,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);
  logic w_invalid;
  // BCD mode shows codes 10..15 as dark segments but keeps the dp
  always_comb begin
    w_invalid = !i_hex && (i_code > 4'd9);
    o_seg = i_blank ? 8'h00 : {w_invalid ? SEG_BLANK : GLYPH[i_code], i_dp};
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: N-digit multiplexed seven-segment scanner with dead-time and frame snapshot
import seg7_pkg::*;
module seg7_scan_ctrl #(
  parameter int N_DIGITS         = 4,
  parameter int DIV              = 50000,
  parameter int DEAD             = 16,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic [N_DIGITS-1:0]     An,
  output logic [7:0]              Cout,
  output logic                    frame_start
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
  localparam logic [IW-1:0] N_M1 = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF = ANODE_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*N_DIGITS-1:0]   r_digits;
  logic [N_DIGITS-1:0]     r_dp;
  logic                    r_hex;
  logic                    r_lz;
  logic [N_DIGITS-1:0]     r_an;
  logic [7:0]              r_cout;
  logic                    r_fs;
  logic                    w_take;
  logic [4*N_DIGITS-1:0]   w_digits;
  logic [N_DIGITS-1:0]     w_dp;
  logic                    w_hex;
  logic                    w_lz;
  logic [N_DIGITS-1:0]     w_blank;
  logic [N_DIGITS-1:0]     w_an_on;
  logic [7:0]              w_seg;
  scan_state_e             w_state;
  // The snapshot is bypassed on the capture cycle so the first slot already sees the new frame
  always_comb begin
    w_take   = en && (r_cnt == '0) && (r_idx == '0);
    w_digits = w_take ? digits : r_digits;
    w_dp     = w_take ? dp : r_dp;
    w_hex    = w_take ? hex_mode : r_hex;
    w_lz     = w_take ? lz_blank : r_lz;
    w_state  = (r_cnt >= DEAD_C) ? ST_ON : ST_DEAD;
    w_an_on  = N_DIGITS'(1) << (N_M1 - r_idx);
  end
  // Leading zeros are blanked left to right until the first nonzero digit or set dp; the rightmost digit always shows
  always_comb begin
    logic lead;
    lead = w_lz;
    w_blank = '0;
    for (int k = 0; k < N_DIGITS - 1; k++) begin
      w_blank[k] = lead && (w_digits[4*k +: 4] == 4'd0) && !w_dp[k];
      lead = w_blank[k];
    end
  end
  seg7_encode u_enc (
    .i_code  (w_digits[4*r_idx +: 4]),
    .i_hex   (w_hex),
    .i_dp    (w_dp[r_idx]),
    .i_blank (w_blank[r_idx]),
    .o_seg   (w_seg)
  );
  // Slot prescaler and digit index; disabling parks the scan at frame start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= (r_cnt == DIV_M1) ? '0 : r_cnt + 1'b1;
      if (r_cnt == DIV_M1) r_idx <= (r_idx == N_M1) ? '0 : r_idx + 1'b1;
    end
  // Per-frame capture of the display inputs to avoid tearing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_hex    <= 1'b0;
      r_lz     <= 1'b0;
    end else if (w_take) begin
      r_digits <= digits;
      r_dp     <= dp;
      r_hex    <= hex_mode;
      r_lz     <= lz_blank;
    end
  // Registered pin drivers: dark during dead-time or when disabled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_an   <= AN_OFF;
      r_cout <= SEG_OFF;
      r_fs   <= 1'b0;
    end else begin
      r_an   <= (en && w_state == ST_ON) ? (ANODE_ACTIVE_LOW ? ~w_an_on : w_an_on) : AN_OFF;
      r_cout <= (en && w_state == ST_ON) ? seg_pol(w_seg, SEG_ACTIVE_LOW) : SEG_OFF;
      r_fs   <= w_take;
    end
  assign An          = r_an;
  assign Cout        = r_cout;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan timing, glyphs, blanking, snapshot and enable/reset
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h4321;
  logic [3:0]  dp = 4'b0000;
  logic        hex_mode = 1'b1;
  logic        lz_blank = 1'b0;
  logic [3:0]  An;
  logic [7:0]  Cout;
  logic        frame_start;
  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.N_DIGITS(4), .DIV(8), .DEAD(2), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .hex_mode(hex_mode),
    .lz_blank(lz_blank), .An(An), .Cout(Cout), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 8'(An), 8'h0F);
    chk("rst_cout", Cout, 8'hFF);
    chk("rst_fs", 8'(frame_start), 8'h00);
    rst = 1'b0;
    en = 1'b1;
    tick(1);
    chk("f1_fs", 8'(frame_start), 8'h01);
    chk("f1_dead0_an", 8'(An), 8'h0F);
    chk("f1_dead0_cout", Cout, 8'hFF);
    tick(1);
    chk("f1_fs_low", 8'(frame_start), 8'h00);
    chk("f1_dead1_an", 8'(An), 8'h0F);
    tick(1);
    chk("d0_on_an", 8'(An), 8'h07);
    chk("d0_on_cout", Cout, 8'h9F);
    tick(5);
    chk("d0_last_an", 8'(An), 8'h07);
    tick(1);
    chk("d1_dead_an", 8'(An), 8'h0F);
    chk("d1_dead_cout", Cout, 8'hFF);
    tick(2);
    chk("d1_on_an", 8'(An), 8'h0B);
    chk("d1_on_cout", Cout, 8'h25);
    tick(8);
    chk("d2_on_an", 8'(An), 8'h0D);
    chk("d2_on_cout", Cout, 8'h0D);
    tick(8);
    chk("d3_on_an", 8'(An), 8'h0E);
    chk("d3_on_cout", Cout, 8'h99);
    tick(5);
    chk("f2_pre_fs", 8'(frame_start), 8'h00);
    tick(1);
    chk("f2_fs", 8'(frame_start), 8'h01);
    digits = 16'h8765;
    tick(2);
    chk("mid_d0_old", Cout, 8'h9F);
    tick(8);
    chk("mid_d1_old", Cout, 8'h25);
    tick(22);
    chk("f3_fs", 8'(frame_start), 8'h01);
    tick(2);
    chk("f3_d0_new", Cout, 8'h49);
    digits = 16'h0C21;
    hex_mode = 1'b0;
    tick(48);
    chk("bcd_c_an", 8'(An), 8'h0D);
    chk("bcd_c_cout", Cout, 8'hFF);
    hex_mode = 1'b1;
    tick(32);
    chk("hex_c_an", 8'(An), 8'h0D);
    chk("hex_c_cout", Cout, 8'h63);
    digits = 16'h7000;
    lz_blank = 1'b1;
    tick(16);
    chk("lz7_d0_an", 8'(An), 8'h07);
    chk("lz7_d0_cout", Cout, 8'hFF);
    tick(8);
    chk("lz7_d1_cout", Cout, 8'hFF);
    tick(8);
    chk("lz7_d2_cout", Cout, 8'hFF);
    tick(8);
    chk("lz7_d3_an", 8'(An), 8'h0E);
    chk("lz7_d3_cout", Cout, 8'h1F);
    digits = 16'h0000;
    tick(8);
    chk("lz0_d0_cout", Cout, 8'hFF);
    tick(24);
    chk("lz0_d3_an", 8'(An), 8'h0E);
    chk("lz0_d3_cout", Cout, 8'h03);
    digits = 16'h0500;
    dp = 4'b0010;
    tick(8);
    chk("lzdp_d0_cout", Cout, 8'hFF);
    tick(8);
    chk("lzdp_d1_cout", Cout, 8'h02);
    tick(8);
    chk("lzdp_d2_cout", Cout, 8'h49);
    tick(8);
    chk("lzdp_d3_cout", Cout, 8'h03);
    en = 1'b0;
    tick(1);
    chk("dis_an", 8'(An), 8'h0F);
    chk("dis_cout", Cout, 8'hFF);
    tick(3);
    chk("dis_hold_an", 8'(An), 8'h0F);
    chk("dis_hold_fs", 8'(frame_start), 8'h00);
    digits = 16'h4321;
    dp = 4'b0000;
    lz_blank = 1'b0;
    en = 1'b1;
    tick(1);
    chk("reen_fs", 8'(frame_start), 8'h01);
    chk("reen_an", 8'(An), 8'h0F);
    tick(2);
    chk("reen_on_an", 8'(An), 8'h07);
    chk("reen_on_cout", Cout, 8'h9F);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 8'(An), 8'h0F);
    chk("arst_cout", Cout, 8'hFF);
    chk("arst_fs", 8'(frame_start), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("post_rst_fs", 8'(frame_start), 8'h01);
    chk("post_rst_an", 8'(An), 8'h0F);
    tick(2);
    chk("post_rst_on_an", 8'(An), 8'h07);
    chk("post_rst_on_cout", Cout, 8'h9F);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
